// File: rtl/pattern_sched.sv
// pattern_sched: time-shared BBCBC sequence detector for NCH serial channels.
// Every channel has a one-symbol holding register and a 3-bit detector
// context. A round-robin arbiter picks one full channel per cycle. The
// shared next-state logic advances that channel's context and reports a
// match through det_o and a saturating per-channel counter.
// Optional build macro: PATTERN_SCHED_FLUSH_EN adds ch_flush_i. That input
// empties a channel's holding register and returns its context to S_RESET.
module pattern_sched #(
  parameter int NCH = 4,
  parameter int CW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    ch_valid_i,
  input  logic [NCH-1:0]    ch_d_i,
  output logic [NCH-1:0]    ch_ready_o,
  input  logic              clr_i,
`ifdef PATTERN_SCHED_FLUSH_EN
  input  logic [NCH-1:0]    ch_flush_i,
`endif
  output logic [NCH-1:0]    det_o,
  output logic [NCH*CW-1:0] det_cnt_o,
  output logic              busy_o
);

  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

  // Symbol encoding: 0 = B, 1 = C. Codes 6 and 7 are unused and behave as S_RESET.
  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_B     = 3'd1,
    S_BB    = 3'd2,
    S_BBC   = 3'd3,
    S_BBCB  = 3'd4,
    S_BBCBC = 3'd5
  } state_t;

  logic [NCH-1:0]         full_q;
  logic [NCH-1:0]         sym_q;
  logic [NCH-1:0]         full_d;
  logic [NCH-1:0]         req;
  logic [NCH-1:0]         grant;
  logic [NCH-1:0]         take;
  logic [NCH-1:0]         flush;
  logic [NCH-1:0]         match;
  logic [NCH-1:0]         det_q;
  logic                   busy_q;
  logic [PW-1:0]          ptr_q;
  logic [PW-1:0]          gnt_idx;
  logic [PW-1:0]          cand;
  logic                   gnt_vld;
  state_t                 ctx_q   [NCH];
  state_t                 ctx_nxt [NCH];
  logic [NCH-1:0][CW-1:0] cnt_q;

`ifdef PATTERN_SCHED_FLUSH_EN
  assign flush = ch_flush_i;
`else
  assign flush = '0;
`endif

  // Overlapping BBCBC matcher, one step for one symbol.
  function automatic state_t next_state(input state_t s, input logic c);
    case (s)
      S_RESET: return c ? S_RESET : S_B;
      S_B:     return c ? S_RESET : S_BB;
      S_BB:    return c ? S_BBC   : S_BB;
      S_BBC:   return c ? S_RESET : S_BBCB;
      S_BBCB:  return c ? S_BBCBC : S_BB;
      S_BBCBC: return c ? S_RESET : S_B;
      default: return c ? S_RESET : S_B;
    endcase
  endfunction

  // A channel being flushed does not take part in arbitration on that edge.
  assign req = full_q & ~flush;

  // Round-robin search. It starts one index past the last grant and wraps modulo NCH.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and set every output first,
    // so no path through the block leaves a variable unassigned and infers a latch.
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int off = 1; off <= NCH; off++) begin
      cand = PW'((int'(ptr_q) + off) % NCH);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // Decode the winning index into a one-hot grant vector.
  always_comb begin
    grant = '0;
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  // A granted register is drained on this edge, so it can also accept a new symbol.
  assign ch_ready_o = ~full_q | grant | flush;
  assign take       = ch_valid_i & ch_ready_o;

  // Next-state values for the holding-register full flags.
  always_comb begin
    full_d = full_q;
    for (int i = 0; i < NCH; i++) begin
      if (flush[i])      full_d[i] = 1'b0;
      else if (take[i])  full_d[i] = 1'b1;
      else if (grant[i]) full_d[i] = 1'b0;
    end
  end

  // Shared next-state engine. Only the granted channel can report a match.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ctx_nxt[i] = next_state(ctx_q[i], sym_q[i]);
      match[i]   = grant[i] && (ctx_nxt[i] == S_BBCBC);
    end
  end

  // Holding registers, arbiter pointer and registered busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q <= '0;
      sym_q  <= '0;
      ptr_q  <= PW'(NCH - 1);
      busy_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking '<=' so that every register
      // samples values from before the edge, whatever order the statements run in.
      full_q <= full_d;
      busy_q <= |full_d;
      if (gnt_vld) ptr_q <= gnt_idx;
      for (int i = 0; i < NCH; i++) begin
        if (take[i] && !flush[i]) sym_q[i] <= ch_d_i[i];
      end
    end
  end

  // Per-channel detector contexts and the one-cycle detect pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the contexts are a small array of flops, not a RAM. Resetting them
      // is cheap, and reset is required to discard partial matches.
      for (int i = 0; i < NCH; i++) ctx_q[i] <= S_RESET;
      det_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (flush[i])      ctx_q[i] <= S_RESET;
        else if (grant[i]) ctx_q[i] <= ctx_nxt[i];
      end
      det_q <= match;
    end
  end

  // Saturating match counters. A clear wins over a match on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (clr_i)                           cnt_q[i] <= '0;
        else if (match[i] && (~&cnt_q[i]))   cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign det_o     = det_q;
  assign det_cnt_o = cnt_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_pattern_sched.sv
// tb_pattern_sched: directed self-checking bench for pattern_sched.
// Uses NCH=4 and CW=2 so that counter saturation is reachable.
// Covers reset, single-channel detection, overlapping matches, round-robin
// fairness, saturation with clear, and flush when PATTERN_SCHED_FLUSH_EN is set.
module tb_pattern_sched;

  localparam int NCH = 4;
  localparam int CW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    ch_valid;
  logic [NCH-1:0]    ch_d;
  logic [NCH-1:0]    ch_ready;
  logic              clr;
  logic [NCH-1:0]    ch_flush;
  logic [NCH-1:0]    det;
  logic [NCH*CW-1:0] det_cnt;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int pulses   [NCH];
  int last_det [NCH];

  pattern_sched #(.NCH(NCH), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_valid_i (ch_valid),
    .ch_d_i     (ch_d),
    .ch_ready_o (ch_ready),
    .clr_i      (clr),
`ifdef PATTERN_SCHED_FLUSH_EN
    .ch_flush_i (ch_flush),
`endif
    .det_o      (det),
    .det_cnt_o  (det_cnt),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int c);
    return 32'(det_cnt[c*CW +: CW]);
  endfunction

  // Step one clock edge and sample 1 time unit later. Detect pulses are logged here.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      if (det[c] === 1'b1) begin
        pulses[c]++;
        last_det[c] = cyc;
      end
    end
  endtask

  task automatic clear_stats();
    for (int c = 0; c < NCH; c++) begin
      pulses[c]   = 0;
      last_det[c] = -1;
    end
  endtask

  task automatic do_reset();
    ch_valid = '0;
    ch_d     = '0;
    clr      = 1'b0;
    ch_flush = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    clear_stats();
  endtask

  // Drive a string of 'B'/'C' symbols into one channel at one per cycle, then idle.
  task automatic feed(input int ch, input string s, input int idle);
    for (int k = 0; k < s.len(); k++) begin
      ch_valid     = '0;
      ch_valid[ch] = 1'b1;
      ch_d[ch]     = (s[k] == "C");
      check($sformatf("ready_ch%0d_sym%0d", ch, k), 32'(ch_ready[ch]), 32'd1);
      tick();
    end
    ch_valid = '0;
    ch_d     = '0;
    repeat (idle) tick();
  endtask

  string fs [NCH];
  int    idx [NCH];
  int    t0;

  initial begin
    rst      = 1'b1;
    ch_valid = '0;
    ch_d     = '0;
    clr      = 1'b0;
    ch_flush = '0;
    clear_stats();

    // ---------------- reset state ----------------
    do_reset();
    #1;
    check("rst_ready", 32'(ch_ready), 32'hF);
    check("rst_det",   32'(det),      32'h0);
    check("rst_cnt",   32'(det_cnt),  32'h0);
    check("rst_busy",  32'(busy),     32'h0);

    // ---------------- single channel ----------------
    tick();
    t0 = cyc;
    feed(0, "BBCBC", 0);
    check("single_no_early_det", 32'(pulses[0]), 32'd0);
    check("single_busy", 32'(busy), 32'd1);
    tick();
    check("single_det", 32'(det), 32'h1);
    check("single_det_time", 32'(last_det[0] - t0), 32'd6);
    tick();
    check("single_det_one_cycle", 32'(det), 32'h0);
    check("single_cnt", 32'(det_cnt), 32'h01);
    check("single_busy_idle", 32'(busy), 32'd0);

    // ---------------- overlap ----------------
    do_reset();
    tick();
    t0 = cyc;
    feed(2, "BBCBBCBC", 3);
    check("overlap_pulses", 32'(pulses[2]), 32'd1);
    check("overlap_det_time", 32'(last_det[2] - t0), 32'd9);
    check("overlap_cnt", 32'(cnt_of(2)), 32'd1);
    do_reset();
    tick();
    feed(2, "BBCBCBBCBC", 3);
    check("overlap2_pulses", 32'(pulses[2]), 32'd2);
    check("overlap2_cnt", 32'(det_cnt), 32'h20);

    // ---------------- fairness ----------------
    do_reset();
    tick();
    fs[0] = "BBCBC";
    fs[1] = "CBBCBC";
    fs[2] = "BBBCBC";
    fs[3] = "BCBBCBC";
    for (int c = 0; c < NCH; c++) idx[c] = 0;
    check("fair_ready_init", 32'(ch_ready), 32'hF);
    for (int n = 1; n <= 40; n++) begin
      for (int c = 0; c < NCH; c++) begin
        ch_valid[c] = (idx[c] < fs[c].len());
        ch_d[c]     = (idx[c] < fs[c].len()) ? (fs[c][idx[c]] == "C") : 1'b0;
      end
      for (int c = 0; c < NCH; c++) begin
        if (ch_valid[c] && ch_ready[c]) idx[c]++;
      end
      tick();
      if (n <= 12) check($sformatf("fair_ready_n%0d", n), 32'(ch_ready), 32'(1 << ((n - 1) % 4)));
    end
    ch_valid = '0;
    ch_d     = '0;
    repeat (4) tick();
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("fair_consumed_ch%0d", c), 32'(idx[c]), 32'(fs[c].len()));
      check($sformatf("fair_pulses_ch%0d", c), 32'(pulses[c]), 32'd1);
    end
    check("fair_cnt", 32'(det_cnt), 32'h55);

    // ---------------- saturation and clear ----------------
    do_reset();
    tick();
    feed(3, "BBCBCBBCBCBBCBCBBCBCBBCBC", 3);
    check("sat_pulses", 32'(pulses[3]), 32'd5);
    check("sat_cnt", 32'(det_cnt), 32'hC0);
    feed(3, "BBCB", 0);
    check("sat_hold", 32'(cnt_of(3)), 32'd3);
    ch_valid[3] = 1'b1;
    ch_d[3]     = 1'b1;
    tick();
    ch_valid = '0;
    ch_d     = '0;
    clr      = 1'b1;
    tick();
    clr      = 1'b0;
    check("clr_det", 32'(det), 32'h8);
    check("clr_cnt", 32'(cnt_of(3)), 32'd0);
    tick();
    check("clr_det_end", 32'(det), 32'h0);
    check("clr_cnt_stays", 32'(cnt_of(3)), 32'd0);

    // ---------------- mid-stream reset ----------------
    do_reset();
    tick();
    feed(1, "BBCBCBBCB", 0);
    check("mrst_cnt_before", 32'(cnt_of(1)), 32'd1);
    check("mrst_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("mrst_ready", 32'(ch_ready), 32'hF);
    check("mrst_det",   32'(det),      32'h0);
    check("mrst_cnt",   32'(det_cnt),  32'h0);
    check("mrst_busy",  32'(busy),     32'h0);
    #2;
    rst = 1'b1;
    clear_stats();
    feed(1, "C", 3);
    check("mrst_c_no_det", 32'(pulses[1]), 32'd0);
    feed(1, "BBCB", 3);
    check("mrst_partial_no_det", 32'(pulses[1]), 32'd0);
    feed(1, "C", 3);
    check("mrst_full_det", 32'(pulses[1]), 32'd1);
    check("mrst_full_cnt", 32'(det_cnt), 32'h04);

`ifdef PATTERN_SCHED_FLUSH_EN
    // ---------------- flush ----------------
    do_reset();
    tick();
    feed(1, "BBCBC", 3);
    feed(1, "BBCB", 0);
    ch_valid[1] = 1'b1;
    ch_d[1]     = 1'b1;
    ch_flush[1] = 1'b1;
    #1;
    check("flush_ready", 32'(ch_ready[1]), 32'd1);
    tick();
    ch_valid = '0;
    ch_d     = '0;
    ch_flush = '0;
    check("flush_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    check("flush_no_det", 32'(pulses[1]), 32'd1);
    feed(1, "C", 3);
    check("flush_c_no_det", 32'(pulses[1]), 32'd1);
    check("flush_cnt_kept", 32'(cnt_of(1)), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
